// File: rtl/call_stack_pkg.sv
// ---- call_stack_pkg : shared op codes, error bit indices and sizing helper (rev 1.0) ----
`default_nettype none

package call_stack_pkg;

   // Op code is {Push, Pop}
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_POP  = 2'b01;
   localparam logic [1:0] OP_PUSH = 2'b10;
   localparam logic [1:0] OP_SWAP = 2'b11;

   // Bit positions shared with the CPU fault register
   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_UNF_BIT = 1;
   localparam int ERR_BITS    = 2;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/call_stack_mem.sv
// ---- call_stack_mem : DEPTH x ADDR_WIDTH storage, falling-edge write, async read (rev 1.0) ----
`default_nettype none

module call_stack_mem #(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [ADDR_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [ADDR_WIDTH-1:0] rdata_o
);

   logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

   // Storage is intentionally left unreset; Count masks stale entries.
   always_ff @(negedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/call_stack.sv
// ---- call_stack : parametrised return-address stack with peek, flush and sticky errors (rev 1.0) ----
`default_nettype none

module call_stack
   import call_stack_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64
) (
   input  logic                              Sys_Clock,
   input  logic                              Reset,
   input  logic                              Push,
   input  logic                              Pop,
   input  logic                              Flush,
   input  logic                              Clear_Err,
   input  logic [ADDR_WIDTH-1:0]             NPPC,
   output logic [ADDR_WIDTH-1:0]             Ret_Add,
   output logic [ADDR_WIDTH-1:0]             Top_Of_Stack,
   output logic [count_width(DEPTH)-1:0]     Count,
   output logic                              Full,
   output logic                              Empty,
   output logic                              Err_Overflow,
   output logic                              Err_Underflow,
   output logic                              Err_Out
);

   localparam int CW = count_width(DEPTH);
   localparam int AW = $clog2(DEPTH);

   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] ret_q, ret_d;
   logic [ERR_BITS-1:0]   err_q, err_d;

   logic [1:0]            w_op;
   logic                  w_full, w_empty;
   logic                  w_we;
   logic [AW-1:0]         w_waddr, w_push_idx, w_top_idx;
   logic [ADDR_WIDTH-1:0] w_rdata;

   assign w_op       = {Push, Pop};
   assign w_full     = (count_q == CW'(DEPTH));
   assign w_empty    = (count_q == '0);
   assign w_push_idx = AW'(count_q);
   assign w_top_idx  = AW'(count_q - CW'(1));

   always_comb begin
      count_d = count_q;
      ret_d   = ret_q;
      err_d   = err_q & {ERR_BITS{~Clear_Err}};
      w_we    = 1'b0;
      w_waddr = w_push_idx;
      if (Flush) begin
         count_d = '0;
      end else begin
         case (w_op)
            OP_PUSH: begin
               if (w_full) begin
                  err_d[ERR_OVF_BIT] = 1'b1;
               end else begin
                  w_we    = 1'b1;
                  count_d = count_q + CW'(1);
               end
            end
            OP_POP: begin
               if (w_empty) begin
                  err_d[ERR_UNF_BIT] = 1'b1;
               end else begin
                  ret_d   = w_rdata;
                  count_d = count_q - CW'(1);
               end
            end
            OP_SWAP: begin
               if (w_empty) begin
                  err_d[ERR_UNF_BIT] = 1'b1;
               end else begin
                  ret_d   = w_rdata;
                  w_we    = 1'b1;
                  w_waddr = w_top_idx;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge Sys_Clock or negedge Reset) begin
      if (!Reset) begin
         count_q <= '0;
         ret_q   <= '0;
         err_q   <= '0;
      end else begin
         count_q <= count_d;
         ret_q   <= ret_d;
         err_q   <= err_d;
      end
   end

   // Write enable is qualified by Reset so an edge inside reset never lands a write.
   call_stack_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk_i   (Sys_Clock),
      .we_i    (w_we & Reset),
      .waddr_i (w_waddr),
      .wdata_i (NPPC),
      .raddr_i (w_top_idx),
      .rdata_o (w_rdata)
   );

   assign Ret_Add       = ret_q;
   assign Top_Of_Stack  = w_empty ? '0 : w_rdata;
   assign Count         = count_q;
   assign Full          = w_full;
   assign Empty         = w_empty;
   assign Err_Overflow  = err_q[ERR_OVF_BIT];
   assign Err_Underflow = err_q[ERR_UNF_BIT];
   assign Err_Out       = |err_q;

endmodule

`default_nettype wire

// File: tb/tb_call_stack.sv
// ---- tb_call_stack : directed scoreboard bench for call_stack at DEPTH=4 and DEPTH=5 (rev 1.0) ----
`default_nettype none

module tb_call_stack;

   logic       clk;
   logic       rst_n;

   logic       a_push, a_pop, a_flush, a_clr;
   logic [7:0] a_nppc, a_ret, a_tos;
   logic [2:0] a_cnt;
   logic       a_full, a_empty, a_ovf, a_unf, a_err;

   logic       b_push, b_pop, b_flush, b_clr;
   logic [7:0] b_nppc, b_ret, b_tos;
   logic [2:0] b_cnt;
   logic       b_full, b_empty, b_ovf, b_unf, b_err;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   call_stack #(.ADDR_WIDTH(8), .DEPTH(4)) dut_a (
      .Sys_Clock(clk), .Reset(rst_n), .Push(a_push), .Pop(a_pop), .Flush(a_flush),
      .Clear_Err(a_clr), .NPPC(a_nppc), .Ret_Add(a_ret), .Top_Of_Stack(a_tos),
      .Count(a_cnt), .Full(a_full), .Empty(a_empty), .Err_Overflow(a_ovf),
      .Err_Underflow(a_unf), .Err_Out(a_err)
   );

   call_stack #(.ADDR_WIDTH(8), .DEPTH(5)) dut_b (
      .Sys_Clock(clk), .Reset(rst_n), .Push(b_push), .Pop(b_pop), .Flush(b_flush),
      .Clear_Err(b_clr), .NPPC(b_nppc), .Ret_Add(b_ret), .Top_Of_Stack(b_tos),
      .Count(b_cnt), .Full(b_full), .Empty(b_empty), .Err_Overflow(b_ovf),
      .Err_Underflow(b_unf), .Err_Out(b_err)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive DUT A at the rising edge, let the falling edge act, sample 1 ns later.
   task automatic op_a(input logic push, input logic pop, input logic flush,
                       input logic clr, input logic [7:0] nppc);
      @(posedge clk);
      a_push = push; a_pop = pop; a_flush = flush; a_clr = clr; a_nppc = nppc;
      @(negedge clk);
      #1;
      a_push = 0; a_pop = 0; a_flush = 0; a_clr = 0;
   endtask

   task automatic chk_ret_sb(input string tag);
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         chk(tag, 32'(a_ret), 32'(sb.pop_front()));
      end
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_cnt"}, 32'(a_cnt), 0);
      chk({tag, "_ret"}, 32'(a_ret), 0);
      chk({tag, "_tos"}, 32'(a_tos), 0);
      chk({tag, "_flags"}, {27'd0, a_empty, a_full, a_ovf, a_unf, a_err}, 32'b10000);
   endtask

   initial begin
      rst_n = 0;
      a_push = 0; a_pop = 0; a_flush = 0; a_clr = 0; a_nppc = '0;
      b_push = 0; b_pop = 0; b_flush = 0; b_clr = 0; b_nppc = '0;
      #1;
      chk_reset_a("por");
      @(posedge clk);
      rst_n = 1;

      // Reset asserted between edges while a push is pending
      op_a(1, 0, 0, 0, 8'h77);
      chk("pre_rst_cnt", 32'(a_cnt), 1);
      @(posedge clk);
      a_push = 1; a_nppc = 8'h88;
      #2 rst_n = 0;
      #1;
      chk_reset_a("async_rst");
      @(negedge clk);
      #1;
      chk("rst_hold_cnt", 32'(a_cnt), 0);
      @(posedge clk);
      a_push = 0;
      rst_n = 1;
      @(negedge clk);
      #1;
      chk("rst_rel_cnt", 32'(a_cnt), 0);
      chk("rst_rel_empty", 32'(a_empty), 1);

      // Underflow on empty: pop and swap
      op_a(0, 1, 0, 0, 8'h00);
      chk("unf_pop", {30'd0, a_unf, a_err}, 32'b11);
      chk("unf_pop_ret", 32'(a_ret), 0);
      op_a(1, 1, 0, 0, 8'hEE);
      chk("unf_swap_cnt", 32'(a_cnt), 0);
      chk("unf_swap_ret", 32'(a_ret), 0);
      chk("unf_swap_tos", 32'(a_tos), 0);
      op_a(0, 1, 0, 1, 8'h00);
      chk("clr_vs_set", 32'(a_unf), 1);
      op_a(0, 0, 0, 1, 8'h00);
      chk("clr_only", {30'd0, a_unf, a_err}, 0);

      // Fill DEPTH=4
      for (int i = 1; i <= 4; i++) begin
         op_a(1, 0, 0, 0, 8'(i * 8'h11));
         chk("push_cnt", 32'(a_cnt), 32'(i));
         chk("push_tos", 32'(a_tos), 32'(i * 8'h11));
         chk("push_full", 32'(a_full), (i == 4) ? 1 : 0);
      end

      // Overflow
      op_a(1, 0, 0, 0, 8'h55);
      chk("ovf_flags", {29'd0, a_ovf, a_err, a_full}, 32'b111);
      chk("ovf_cnt", 32'(a_cnt), 4);
      chk("ovf_tos", 32'(a_tos), 8'h44);

      // Drain
      for (int i = 4; i >= 1; i--) begin
         sb.push_back(8'(i * 8'h11));
         op_a(0, 1, 0, 0, 8'h00);
         chk_ret_sb("pop_ret");
         chk("pop_ovf_sticky", 32'(a_ovf), 1);
      end
      chk("drain_empty", {30'd0, a_empty, a_full}, 32'b10);
      op_a(0, 0, 0, 1, 8'h00);
      chk("ovf_cleared", {30'd0, a_ovf, a_err}, 0);

      // Swap on [0x10,0x20]
      op_a(1, 0, 0, 0, 8'h10);
      op_a(1, 0, 0, 0, 8'h20);
      sb.push_back(8'h20);
      op_a(1, 1, 0, 0, 8'h99);
      chk_ret_sb("swap_ret");
      chk("swap_tos", 32'(a_tos), 8'h99);
      chk("swap_cnt", 32'(a_cnt), 2);
      sb.push_back(8'h99);
      op_a(0, 1, 0, 0, 8'h00);
      chk_ret_sb("after_swap_pop");
      chk("after_swap_tos", 32'(a_tos), 8'h10);

      // Flush wins over a same-cycle push
      op_a(1, 0, 0, 0, 8'hA1);
      op_a(1, 0, 0, 0, 8'hA2);
      chk("pre_flush_cnt", 32'(a_cnt), 3);
      op_a(1, 0, 1, 0, 8'hAB);
      chk("flush_cnt", 32'(a_cnt), 0);
      chk("flush_empty", 32'(a_empty), 1);
      chk("flush_tos", 32'(a_tos), 0);
      chk("flush_ret", 32'(a_ret), 8'h99);
      op_a(1, 0, 0, 0, 8'h01);
      chk("post_flush_tos", 32'(a_tos), 8'h01);
      chk("post_flush_cnt", 32'(a_cnt), 1);

      // DEPTH=5: full only at Count=5
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk);
         b_push = 1; b_nppc = 8'(8'hB0 + i);
         @(negedge clk);
         #1;
         b_push = 0;
         chk("d5_cnt", 32'(b_cnt), 32'(i));
         chk("d5_full", 32'(b_full), (i == 5) ? 1 : 0);
      end
      @(posedge clk);
      b_push = 1; b_nppc = 8'hCC;
      @(negedge clk);
      #1;
      b_push = 0;
      chk("d5_ovf", {30'd0, b_ovf, b_err}, 32'b11);
      chk("d5_ovf_tos", 32'(b_tos), 8'hB5);
      @(posedge clk);
      b_pop = 1;
      @(negedge clk);
      #1;
      b_pop = 0;
      chk("d5_pop_ret", 32'(b_ret), 8'hB5);
      chk("d5_pop_full", 32'(b_full), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/call_stack.md
# call_stack

Parametrised hardware return-address stack for the processor control path: it pushes the next-PC value on call, pops it on return, and supports a simultaneous push+pop (replace-top) for call-from-return sequences. It generalises the single-op 64×8 stack to configurable width and depth. It adds exact full/empty detection, an occupancy count, a peek port, flush, and sticky overflow/underflow flags feeding the CPU fault logic.

## Interface
- ADDR_WIDTH, 8, width of stored return addresses
- DEPTH, 64, number of entries; any value ≥ 2, not required to be a power of two
- Sys_Clock  input  1  system clock; all state changes on its falling edge
- Reset  input  1  asynchronous, active-low reset
- Push  input  1  push NPPC this cycle
- Pop  input  1  pop top entry into Ret_Add this cycle
- Flush  input  1  synchronous discard of all entries
- Clear_Err  input  1  synchronous clear of sticky error flags
- NPPC  input  ADDR_WIDTH  address to push
- Ret_Add  output  ADDR_WIDTH  registered value of the last successful pop
- Top_Of_Stack  output  ADDR_WIDTH  combinational peek of the top entry; 0 when empty
- Count  output  $clog2(DEPTH+1)  current occupancy
- Full  output  1  Count == DEPTH
- Empty  output  1  Count == 0
- Err_Overflow  output  1  sticky: a push was refused
- Err_Underflow  output  1  sticky: a pop was refused
- Err_Out  output  1  Err_Overflow | Err_Underflow

## Operation
- Ops decode from {Push, Pop}: NONE, PUSH, POP, SWAP (both set).
- Priority: Reset > Flush > op. Flush sets Count=0 and ignores Push/Pop that cycle. Flush does not alter Ret_Add or the error flags.
- PUSH, not full: mem[Count] ← NPPC; Count+1.
- PUSH, full: no write; Count unchanged; Err_Overflow ← 1.
- POP, not empty: Ret_Add ← mem[Count-1]; Count−1.
- POP, empty: Ret_Add unchanged; Err_Underflow ← 1.
- SWAP, not empty: Ret_Add ← mem[Count-1]; mem[Count-1] ← NPPC; Count unchanged. This is legal when full.
- SWAP, empty: no write; Ret_Add unchanged; Err_Underflow ← 1.
- Clear_Err clears both flags. If the same cycle also raises an error, the set wins.
- Storage is never reset. Entries at or above Count are don't-care and must not reach any output.
- Count arithmetic uses the full $clog2(DEPTH+1) width. No wrap is permitted; full/empty is decided from Count, never from pointer equality.

## Timing
- Reset assertion (async) sets, without waiting for a clock edge: Count=0, Ret_Add=0, Empty=1, Full=0, Err_Overflow=0, Err_Underflow=0, Err_Out=0. Top_Of_Stack=0.
- Reset is released synchronously to the falling edge internally. The first op is accepted on the first falling edge after deassertion.
- Reset mid-operation discards the in-flight op. No partial write is permitted.
- Ret_Add is valid immediately after the falling edge that completes a POP or SWAP. It holds until the next successful POP or SWAP, giving one half-cycle of setup to the rising-edge PC register.
- Full, Empty, Count and the error flags are registered, or decoded from registered Count. They update on the same falling edge as the op.
- Top_Of_Stack follows Count and memory combinationally. After a PUSH it reflects NPPC from that edge onward.
- Throughput is one op per cycle, with no stall and no back-pressure.

## Structure
- Shared package (call_stack_pkg) holds:
  - op encoding localparams OP_NONE/OP_PUSH/OP_POP/OP_SWAP;
  - the count-width function;
  - the error-flag bit indices shared with the CPU fault register.
- One sub-module, call_stack_mem:
  - DEPTH × ADDR_WIDTH array;
  - one synchronous falling-edge write port;
  - one asynchronous read port addressed by Count-1.
- Top level holds Count, Ret_Add, flags and op decode.

## Test plan
- Reset low mid-PUSH: all outputs reach reset values before the next edge. After release, Empty=1 and Count=0.
- DEPTH=4, push 0x11,0x22,0x33,0x44, then pop ×4 → Ret_Add sequence 0x44,0x33,0x22,0x11, Full=1 after the 4th push, Empty=1 at the end.
- DEPTH=4 full, push 0x55 → Err_Overflow=1, Err_Out=1, Count=4. The next pop returns 0x44 and Err_Overflow stays 1 until Clear_Err.
- Empty stack, pop → Err_Underflow=1, Ret_Add unchanged (0). SWAP on empty → same, no write.
- Stack [0x10,0x20], SWAP with NPPC=0x99 → Ret_Add=0x20, Top_Of_Stack=0x99, Count=2. A following pop returns 0x99.
- Stack with 3 entries, Flush+Push same cycle → Count=0, Empty=1, no write. DEPTH=5 run exercises the non-power-of-two full detection (Full at Count=5).
